multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/alu_op_pkg.sv | 85 ++++++++
 rtl/instr_decoder.sv | 120 ++++++++++++
 rtl/multicycle_control_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_op_pkg.sv
// Shared types and constants for the multicycle control unit: FSM state
// encoding, opcodes, ALU operations (including the M-extension ops), and
// the decoded control word.
package alu_op_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef logic [2:0] mcu_state_t;
  localparam mcu_state_t ST_IDLE   = 3'd0;
  localparam mcu_state_t ST_DECODE = 3'd1;
  localparam mcu_state_t ST_EXEC   = 3'd2;
  localparam mcu_state_t ST_MEM    = 3'd3;
  localparam mcu_state_t ST_WB     = 3'd4;
  localparam mcu_state_t ST_TRAP   = 3'd5;

  typedef logic [4:0] alu_op_t;
  localparam alu_op_t ALU_ADD    = 5'd0;
  localparam alu_op_t ALU_SUB    = 5'd1;
  localparam alu_op_t ALU_SLL    = 5'd2;
  localparam alu_op_t ALU_SLT    = 5'd3;
  localparam alu_op_t ALU_SLTU   = 5'd4;
  localparam alu_op_t ALU_XOR    = 5'd5;
  localparam alu_op_t ALU_SRL    = 5'd6;
  localparam alu_op_t ALU_SRA    = 5'd7;
  localparam alu_op_t ALU_OR     = 5'd8;
  localparam alu_op_t ALU_AND    = 5'd9;
  // M-extension ops occupy ALU_MUL + funct3
  localparam alu_op_t ALU_MUL    = 5'd10;
  localparam alu_op_t ALU_MULH   = 5'd11;
  localparam alu_op_t ALU_MULHSU = 5'd12;
  localparam alu_op_t ALU_MULHU  = 5'd13;
  localparam alu_op_t ALU_DIV    = 5'd14;
  localparam alu_op_t ALU_DIVU   = 5'd15;
  localparam alu_op_t ALU_REM    = 5'd16;
  localparam alu_op_t ALU_REMU   = 5'd17;

  typedef logic [2:0] br_type_t;
  localparam br_type_t BR_NONE = 3'd0;
  localparam br_type_t BR_EQ   = 3'd1;
  localparam br_type_t BR_NE   = 3'd2;
  localparam br_type_t BR_LT   = 3'd3;
  localparam br_type_t BR_GE   = 3'd4;

  typedef logic [2:0] imm_sel_t;
  localparam imm_sel_t IMM_NONE = 3'd0;
  localparam imm_sel_t IMM_I    = 3'd1;
  localparam imm_sel_t IMM_S    = 3'd2;
  localparam imm_sel_t IMM_B    = 3'd3;
  localparam imm_sel_t IMM_U    = 3'd4;
  localparam imm_sel_t IMM_J    = 3'd5;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] mem_read_size;
    logic       mem_read_signed;
    br_type_t   branch_type;
    logic       branch_signed;
    imm_sel_t   sel_imm;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
  } ctrl_t;

  // Byte enables for SB/SH/SW; anything else writes nothing.
  function automatic logic [3:0] store_byte_en(input logic [2:0] funct3);
    case (funct3)
      3'b000:  store_byte_en = 4'b0001;
      3'b001:  store_byte_en = 4'b0011;
      3'b010:  store_byte_en = 4'b1111;
      default: store_byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32 instruction decoder: instruction word -> control word
// plus an illegal flag. MCU_MEXT_EN enables decoding of MUL..REMU
// (OP with funct7 = 0000001); without it those encodings are illegal.
// Illegal encodings always produce an all-zero control word.
import alu_op_pkg::*;

module instr_decoder (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Base integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_op_t base_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_alu_op = ALU_SLL;
      3'b010:  base_alu_op = ALU_SLT;
      3'b011:  base_alu_op = ALU_SLTU;
      3'b100:  base_alu_op = ALU_XOR;
      3'b101:  base_alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_alu_op = ALU_OR;
      default: base_alu_op = ALU_AND;
    endcase
  endfunction

  // Decode opcode/funct fields into control fields and legality.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.alu_src         = 1'b1;
        ctrl.mem_to_reg      = 1'b1;
        ctrl.sel_imm         = IMM_I;
        ctrl.mem_read_size   = funct3[1:0];
        ctrl.mem_read_signed = ~funct3[2];
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        ctrl.alu_src = 1'b1;
        ctrl.sel_imm = IMM_S;
        illegal      = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        ctrl.alu_op        = ALU_SUB;
        ctrl.sel_imm       = IMM_B;
        ctrl.branch_signed = funct3[2] & ~funct3[1];
        case (funct3)
          3'b000:  ctrl.branch_type = BR_EQ;
          3'b001:  ctrl.branch_type = BR_NE;
          3'b100:  ctrl.branch_type = BR_LT;
          3'b101:  ctrl.branch_type = BR_GE;
          3'b110:  ctrl.branch_type = BR_LT;
          3'b111:  ctrl.branch_type = BR_GE;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          ctrl.alu_op = base_alu_op(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ctrl.alu_op = base_alu_op(funct3, 1'b1);
`ifdef MCU_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          ctrl.alu_op = ALU_MUL + alu_op_t'(funct3);
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ctrl.alu_src = 1'b1;
        ctrl.sel_imm = IMM_I;
        if (funct3 == 3'b001) begin
          ctrl.alu_op = ALU_SLL;
          illegal     = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          ctrl.alu_op = base_alu_op(funct3, funct7[5]);
          illegal     = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else begin
          ctrl.alu_op = base_alu_op(funct3, 1'b0);
        end
      end
      OPC_JAL: begin
        ctrl.jal     = 1'b1;
        ctrl.sel_imm = IMM_J;
      end
      OPC_JALR: begin
        ctrl.jalr    = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.sel_imm = IMM_I;
        illegal      = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        ctrl.lui     = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.sel_imm = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.auipc   = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.sel_imm = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: IDLE -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE,
// with TRAP for illegal instructions and memory timeouts.
// Optional feature macro: MCU_MEXT_EN (M-extension mul/div handshake in EXEC).
import alu_op_pkg::*;

module multicycle_control_unit #(
  parameter int          XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            mem_ack,
  input  logic            md_done,
  input  logic            trap_clr,
  output ctrl_t           ctrl,
  output logic            mem_req,
  output logic [3:0]      mem_we,
  output logic            reg_we,
  output logic            pc_en,
  output logic            md_start,
  output logic            retire,
  output logic            trap,
  output mcu_state_t      state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  if (XLEN != 32) begin : g_xlen_check
    $error("multicycle_control_unit: XLEN must be 32");
  end

  mcu_state_t       state_q, state_d;
  logic [XLEN-1:0]  instr_q;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             is_load, is_store, is_branch;
  logic             timeout_hit;

  instr_decoder u_decoder (
    .instr   (instr_q[31:0]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign is_load   = (instr_q[6:0] == OPC_LOAD);
  assign is_store  = (instr_q[6:0] == OPC_STORE);
  assign is_branch = (instr_q[6:0] == OPC_BRANCH);

  // Timeout fires on the cycle the wait counter would reach MEM_TIMEOUT.
  assign timeout_hit = (MEM_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == MEM_TIMEOUT);

`ifdef MCU_MEXT_EN
  logic is_md, md_busy_q;
  assign is_md = (instr_q[6:0] == OPC_OP) && (instr_q[31:25] == 7'b0000001);

  // Marks that md_start has been issued and the unit is waiting on md_done.
  always_ff @(posedge clk) begin
    if (!rst_n) md_busy_q <= 1'b0;
    else        md_busy_q <= (state_q == ST_EXEC) && is_md && !(md_busy_q && md_done);
  end

  assign md_start = (state_q == ST_EXEC) && is_md && !md_busy_q;
`else
  logic md_unused;
  assign md_unused = md_done;
  assign md_start  = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        if (is_load || is_store) state_d = ST_MEM;
        else if (is_branch)      state_d = ST_IDLE;
`ifdef MCU_MEXT_EN
        else if (is_md) begin
          if (md_busy_q && md_done) state_d = ST_WB;
        end
`endif
        else state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ack)          state_d = is_load ? ST_WB : ST_IDLE;
        else if (timeout_hit) state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_IDLE;
      ST_TRAP: if (trap_clr) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Instruction latch on accept; data only, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && instr_valid) instr_q <= instr;
  end

  // Control word is captured from the decoder during DECODE and held.
  always_ff @(posedge clk) begin
    if (!rst_n)                    ctrl_q <= '0;
    else if (state_q == ST_DECODE) ctrl_q <= dec_ctrl;
  end

  // MEM wait counter: zero outside MEM, counts cycles without mem_ack.
  always_ff @(posedge clk) begin
    if (!rst_n)                                           cnt_q <= '0;
    else if (state_q != ST_MEM)                           cnt_q <= '0;
    else if (!mem_ack && MEM_TIMEOUT != 0 && !timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign state       = state_q;
  assign ctrl        = ctrl_q;
  assign instr_ready = (state_q == ST_IDLE);
  assign mem_req     = (state_q == ST_MEM);
  assign mem_we      = (state_q == ST_MEM && is_store) ? store_byte_en(instr_q[14:12]) : 4'b0000;
  assign reg_we      = (state_q == ST_WB);
  assign retire      = (state_q == ST_WB)
                     || (state_q == ST_EXEC && is_branch)
                     || (state_q == ST_MEM && is_store && mem_ack);
  assign pc_en       = retire;
  assign trap        = (state_q == ST_TRAP);

endmodule
